// File: rtl/mips_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: FSM encoding,
// the NOP used for bubbles, and the default reset PC.
package mips_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Bundle of hazard/redirect controls, program-memory port and IF/ID outputs
// of the fetch stage. The fetch stage is the slave; its environment is the master.
interface mips_fetch_stage_if;

    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        halted_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    modport slave (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_addr_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o,
               halted_o, misalign_o, fetch_count_o
    );

    modport master (
        output stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_addr_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o,
               halted_o, misalign_o, fetch_count_o
    );

endinterface

// File: rtl/mips_fetch_stage_fetch_pipe_reg.sv
// One IF/ID pipeline field: async reset to zero, synchronous clear to a
// bubble value (wins over load), otherwise load when enabled, else hold.
module fetch_pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = CLEAR_VAL;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// IF stage of the pipelined MIPS core: PC, fetch FSM, fetch counter and
// the IF/ID pipeline register.
//
//   state | meaning
//   BOOT  | first edge after reset; IF/ID gets a bubble, PC held
//   RUN   | normal fetch; redirect > stall > PC+4
//   HALT  | PC past program memory; bubbles until a redirect
module mips_fetch_stage
    import mips_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int          MEMORY_DEPTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    mips_fetch_stage_if.slave  bus
);

    localparam logic [31:0] FETCH_LIMIT = 32'(4 * MEMORY_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_tgt;
    logic         redirect_misaligned;
    logic         load;
    logic         bubble;

    assign pc_plus4            = pc_q + 32'd4;
    assign redirect_tgt        = align_word(bus.redirect_pc_i);
    assign redirect_misaligned = |bus.redirect_pc_i[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        load       = 1'b0;
        bubble     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                bubble  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.redirect_i) begin
                    pc_d       = redirect_tgt;
                    misalign_d = misalign_q | redirect_misaligned;
                    bubble     = 1'b1;
                end else if (bus.stall_i) begin
                    bubble = bus.flush_i;
                end else begin
                    bubble = bus.flush_i;
                    load   = ~bus.flush_i;
                    // Last word in memory: keep PC on it and stop fetching.
                    if (pc_plus4 >= FETCH_LIMIT) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_HALT: begin
                bubble = 1'b1;
                if (bus.redirect_i) begin
                    pc_d       = redirect_tgt;
                    misalign_d = misalign_q | redirect_misaligned;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                bubble  = 1'b1;
                state_d = ST_BOOT;
            end
        endcase
        count_d = count_q + {31'd0, load};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            count_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // PC+4 survives a bubble; only instruction and valid are cleared.
    fetch_pipe_reg #(.WIDTH(32), .CLEAR_VAL(32'd0)) u_pc4 (
        .clk (clk), .rst (reset), .en (load), .clr (1'b0),
        .d   (pc_plus4), .q (bus.if_id_pc4_o)
    );

    fetch_pipe_reg #(.WIDTH(32), .CLEAR_VAL(NOP_INSTR)) u_instr (
        .clk (clk), .rst (reset), .en (load), .clr (bubble),
        .d   (bus.imem_data_i), .q (bus.if_id_instr_o)
    );

    fetch_pipe_reg #(.WIDTH(1), .CLEAR_VAL(1'b0)) u_valid (
        .clk (clk), .rst (reset), .en (load), .clr (bubble),
        .d   (1'b1), .q (bus.if_id_valid_o)
    );

    assign bus.imem_addr_o   = pc_q;
    assign bus.halted_o      = (state_q == ST_HALT);
    assign bus.misalign_o    = misalign_q;
    assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: two instances (64-word and 4-word memory) driven
// by directed scenarios and random traffic, checked against a per-edge model.
module tb_mips_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic        valid;
        logic        halt;
        logic        boot;
        logic        mis;
    } model_t;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] mem [0:63];
    int n_checks = 0;
    int n_err    = 0;
    model_t m_a, m_b;

    mips_fetch_stage_if bus_a ();
    mips_fetch_stage_if bus_b ();

    mips_fetch_stage #(.RESET_PC(32'h0), .MEMORY_DEPTH(64)) dut_a (
        .clk (clk), .reset (reset), .bus (bus_a)
    );
    mips_fetch_stage #(.RESET_PC(32'h0), .MEMORY_DEPTH(4)) dut_b (
        .clk (clk), .reset (reset), .bus (bus_b)
    );

    always #5 clk = ~clk;

    always_comb bus_a.imem_data_i = (bus_a.imem_addr_o < 32'd256) ?
        mem[bus_a.imem_addr_o[7:2]] : (bus_a.imem_addr_o ^ 32'hA5A5_5A5A);
    always_comb bus_b.imem_data_i = (bus_b.imem_addr_o < 32'd256) ?
        mem[bus_b.imem_addr_o[7:2]] : (bus_b.imem_addr_o ^ 32'hA5A5_5A5A);

    function automatic logic [31:0] imem_read(input logic [31:0] addr);
        return (addr < 32'd256) ? mem[addr[7:2]] : (addr ^ 32'hA5A5_5A5A);
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m = '0;
        m.boot = 1'b1;
        return m;
    endfunction

    // One clock edge of the fetch stage, from the architectural rules.
    function automatic model_t step(input model_t m, input logic st, fl, rd,
                                    input logic [31:0] tgt, limit, word);
        model_t n;
        n = m;
        if (m.boot) begin
            n.boot = 1'b0; n.valid = 1'b0; n.instr = 32'h0;
        end else if (m.halt || rd) begin
            n.valid = 1'b0; n.instr = 32'h0;
            if (rd) begin
                n.halt = 1'b0;
                n.pc   = tgt - (tgt % 4);
                if (tgt % 4 != 0) n.mis = 1'b1;
            end
        end else if (st) begin
            if (fl) begin n.valid = 1'b0; n.instr = 32'h0; end
        end else begin
            if (fl) begin
                n.valid = 1'b0; n.instr = 32'h0;
            end else begin
                n.valid = 1'b1; n.instr = word; n.pc4 = m.pc + 4; n.cnt = m.cnt + 1;
            end
            if (m.pc + 32'd4 >= limit) n.halt = 1'b1;
            else                       n.pc   = m.pc + 4;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string nm, input model_t m,
                             input logic [31:0] addr, pc4, instr, cnt,
                             input logic valid, halted, mis);
        chk({nm, "_addr"},  addr,  m.pc);
        chk({nm, "_pc4"},   pc4,   m.pc4);
        chk({nm, "_instr"}, instr, m.instr);
        chk({nm, "_count"}, cnt,   m.cnt);
        chk({nm, "_valid"}, {31'd0, valid},  {31'd0, m.valid});
        chk({nm, "_halt"},  {31'd0, halted}, {31'd0, m.halt});
        chk({nm, "_mis"},   {31'd0, mis},    {31'd0, m.mis});
    endtask

    task automatic check_both();
        check_dut("A", m_a, bus_a.imem_addr_o, bus_a.if_id_pc4_o, bus_a.if_id_instr_o,
                  bus_a.fetch_count_o, bus_a.if_id_valid_o, bus_a.halted_o, bus_a.misalign_o);
        check_dut("B", m_b, bus_b.imem_addr_o, bus_b.if_id_pc4_o, bus_b.if_id_instr_o,
                  bus_b.fetch_count_o, bus_b.if_id_valid_o, bus_b.halted_o, bus_b.misalign_o);
    endtask

    task automatic drive(input logic st, fl, rd, input logic [31:0] tgt);
        bus_a.stall_i = st; bus_a.flush_i = fl; bus_a.redirect_i = rd; bus_a.redirect_pc_i = tgt;
        bus_b.stall_i = st; bus_b.flush_i = fl; bus_b.redirect_i = rd; bus_b.redirect_pc_i = tgt;
    endtask

    task automatic cycle(input logic st, fl, rd, input logic [31:0] tgt);
        drive(st, fl, rd, tgt);
        @(posedge clk);
        m_a = step(m_a, st, fl, rd, tgt, 32'd256, imem_read(m_a.pc));
        m_b = step(m_b, st, fl, rd, tgt, 32'd16,  imem_read(m_b.pc));
        @(negedge clk);
        check_both();
    endtask

    initial begin
        logic st, fl, rd;
        logic [31:0] tgt;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        m_a = model_reset();
        m_b = model_reset();
        #1;
        check_both();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Boot bubble, then first real fetch.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_boot_valid", {31'd0, bus_a.if_id_valid_o}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_instr", bus_a.if_id_instr_o, 32'h2008_0005);
        chk("t1_pc4",   bus_a.if_id_pc4_o,   32'h4);
        chk("t1_count", bus_a.fetch_count_o, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Stall three cycles at PC=8.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            chk("t2_pc_hold", bus_a.imem_addr_o, 32'h8);
            chk("t2_count",   bus_a.fetch_count_o, 32'd2);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_resume_pc4", bus_a.if_id_pc4_o, 32'hC);

        // Small-memory instance halts after delivering the word at 0xC.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5_halted", {31'd0, bus_b.halted_o}, 32'd1);
        chk("t5_pc",     bus_b.imem_addr_o, 32'hC);
        chk("t5_instr",  bus_b.if_id_instr_o, mem[3]);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5_bubble", {31'd0, bus_b.if_id_valid_o}, 32'd0);
        chk("t5_pc_frz", bus_b.imem_addr_o, 32'hC);

        // Redirect during stall.
        cycle(1'b1, 1'b0, 1'b1, 32'h20);
        chk("t3_pc",     bus_a.imem_addr_o, 32'h20);
        chk("t3_bubble", {31'd0, bus_a.if_id_valid_o}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3_instr",  bus_a.if_id_instr_o, mem[8]);
        chk("t3_pc4",    bus_a.if_id_pc4_o, 32'h24);

        // Misaligned redirect target.
        cycle(1'b0, 1'b0, 1'b1, 32'h1E);
        chk("t4_pc",  bus_a.imem_addr_o, 32'h1C);
        chk("t4_mis", {31'd0, bus_a.misalign_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            chk("t4_mis_sticky", {31'd0, bus_a.misalign_o}, 32'd1);
        end

        // Redirect out of HALT.
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        chk("t5_resume_halt", {31'd0, bus_b.halted_o}, 32'd0);
        chk("t5_resume_pc",   bus_b.imem_addr_o, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5_resume_instr", bus_b.if_id_instr_o, 32'h2008_0005);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 6) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            tgt = 32'($urandom_range(0, 80)) * 32'd4;
            if ($urandom_range(0, 3) == 0) tgt = tgt + 32'($urandom_range(1, 3));
            cycle(st, fl, rd, tgt);
        end

        // Async reset mid-run with flush asserted.
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        m_a = model_reset();
        m_b = model_reset();
        check_both();
        chk("t6_count", bus_a.fetch_count_o, 32'd0);
        @(negedge clk);
        check_both();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
